// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage between execute and writeback: issues aligned byte/half/word
// loads and stores over a req/gnt/rvalid port, passes other ops through with one cycle of latency.
module mem_access_stage #(
    parameter int ADDR_W  = 20,
    parameter int DATA_W  = 32,
    parameter int IDX_W   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst_async_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_is_load,
    input  logic              in_is_store,
    input  logic [1:0]        in_size,
    input  logic              in_unsigned,
    input  logic [DATA_W-1:0] in_data,
    input  logic [DATA_W-1:0] in_store_data,
    input  logic [IDX_W-1:0]  in_rd,
    output logic              mem_req,
    input  logic              mem_gnt,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IDX_W-1:0]  out_rd,
    output logic [DATA_W-1:0] out_result,
    output logic              out_fault
);
    localparam int NB        = DATA_W / 8;
    localparam int LB        = $clog2(NB);
    localparam int CNT_W     = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam int TO_LAST_I = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_LAST_I);
    localparam logic [2:0] LB3 = 3'((LB > 7) ? 7 : LB);
    localparam int SB2 = (DATA_W >= 32) ? 31 : DATA_W - 1;
    localparam int SB3 = (DATA_W >= 64) ? 63 : DATA_W - 1;

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_DRAIN} state_t;

    state_t              state_reg, state_next;
    logic [CNT_W-1:0]    cnt_reg, cnt_next;
    logic                mem_req_reg, mem_req_next, mem_we_reg, mem_we_next;
    logic [ADDR_W-1:0]   mem_addr_reg, mem_addr_next;
    logic [NB-1:0]       mem_be_reg, mem_be_next;
    logic [DATA_W-1:0]   mem_wdata_reg, mem_wdata_next;
    logic                out_valid_reg, out_valid_next, out_fault_reg, out_fault_next;
    logic [DATA_W-1:0]   out_result_reg, out_result_next;
    logic [IDX_W-1:0]    out_rd_reg, out_rd_next;
    logic [DATA_W-1:0]   addr_reg, addr_next;
    logic [LB-1:0]       lane_reg, lane_next;
    logic [1:0]          size_reg, size_next;
    logic                unsigned_reg, unsigned_next, store_reg, store_next;

    logic                accept, in_is_mem, in_fault, timeout_hit;
    logic [2:0]          in_mask;
    logic [NB-1:0]       be_base;
    logic [DATA_W-1:0]   wdata_rep, rd_shifted, load_ext;
    logic                load_sign, load_fill;

    assign in_ready    = (state_reg == ST_IDLE) && (!out_valid_reg || out_ready);
    assign accept      = in_valid && in_ready;
    assign in_is_mem   = in_is_load || in_is_store;
    assign in_mask     = (3'd1 << in_size) - 3'd1;
    assign in_fault    = in_is_mem && (({1'b0, in_size} > LB3) || ((in_data[2:0] & in_mask) != 3'd0));
    assign timeout_hit = (TIMEOUT != 0) && (cnt_reg == TO_LAST);

    always_comb begin
        case (in_size)
            2'd0:    be_base = NB'(8'h01);
            2'd1:    be_base = NB'(8'h03);
            2'd2:    be_base = NB'(8'h0F);
            default: be_base = NB'(8'hFF);
        endcase
    end

    // Each write lane repeats the low 2^size store bytes; source byte is lane modulo access size.
    for (genvar gi = 0; gi < NB; gi++) begin : g_wlane
        logic [7:0] src_byte;
        always_comb begin
            case (in_size)
                2'd0:    src_byte = in_store_data[7:0];
                2'd1:    src_byte = in_store_data[8*(gi % 2) +: 8];
                2'd2:    src_byte = in_store_data[8*(gi % 4) +: 8];
                default: src_byte = in_store_data[8*(gi % 8) +: 8];
            endcase
        end
        assign wdata_rep[8*gi +: 8] = src_byte;
    end

    assign rd_shifted = mem_rdata >> {lane_reg, 3'b000};

    always_comb begin
        case (size_reg)
            2'd0:    load_sign = rd_shifted[7];
            2'd1:    load_sign = rd_shifted[15];
            2'd2:    load_sign = rd_shifted[SB2];
            default: load_sign = rd_shifted[SB3];
        endcase
        load_fill = !unsigned_reg && load_sign;
    end

    for (genvar gi = 0; gi < NB; gi++) begin : g_rlane
        localparam bit K0 = (gi < 1);
        localparam bit K1 = (gi < 2);
        localparam bit K2 = (gi < 4);
        localparam bit K3 = (gi < 8);
        logic keep;
        always_comb begin
            case (size_reg)
                2'd0:    keep = K0;
                2'd1:    keep = K1;
                2'd2:    keep = K2;
                default: keep = K3;
            endcase
        end
        assign load_ext[8*gi +: 8] = keep ? rd_shifted[8*gi +: 8] : {8{load_fill}};
    end

    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        mem_req_next    = mem_req_reg;
        mem_we_next     = mem_we_reg;
        mem_addr_next   = mem_addr_reg;
        mem_be_next     = mem_be_reg;
        mem_wdata_next  = mem_wdata_reg;
        out_valid_next  = out_valid_reg;
        out_fault_next  = out_fault_reg;
        out_result_next = out_result_reg;
        out_rd_next     = out_rd_reg;
        addr_next       = addr_reg;
        lane_next       = lane_reg;
        size_next       = size_reg;
        unsigned_next   = unsigned_reg;
        store_next      = store_reg;

        if (out_valid_reg && out_ready) begin
            out_valid_next = 1'b0;
        end

        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    out_rd_next = in_rd;
                    cnt_next    = '0;
                    if (!in_is_mem || in_fault) begin
                        out_valid_next  = 1'b1;
                        out_fault_next  = in_fault;
                        out_result_next = in_data;
                    end else begin
                        state_next     = ST_REQ;
                        mem_req_next   = 1'b1;
                        mem_we_next    = in_is_store;
                        mem_addr_next  = {in_data[ADDR_W-1:LB], {LB{1'b0}}};
                        mem_be_next    = be_base << in_data[LB-1:0];
                        mem_wdata_next = wdata_rep;
                        addr_next      = in_data;
                        lane_next      = in_data[LB-1:0];
                        size_next      = in_size;
                        unsigned_next  = in_unsigned;
                        store_next     = in_is_store;
                    end
                end
            end
            ST_REQ: begin
                cnt_next = cnt_reg + CNT_W'(1);
                if (mem_gnt) begin
                    mem_req_next = 1'b0;
                    mem_we_next  = 1'b0;
                    if (store_reg) begin
                        state_next      = ST_IDLE;
                        out_valid_next  = 1'b1;
                        out_fault_next  = 1'b0;
                        out_result_next = addr_reg;
                    end else begin
                        state_next = ST_WAIT;
                    end
                end else if (timeout_hit) begin
                    mem_req_next    = 1'b0;
                    mem_we_next     = 1'b0;
                    state_next      = ST_IDLE;
                    out_valid_next  = 1'b1;
                    out_fault_next  = 1'b1;
                    out_result_next = addr_reg;
                end
            end
            ST_WAIT: begin
                cnt_next = cnt_reg + CNT_W'(1);
                if (mem_rvalid) begin
                    state_next      = ST_IDLE;
                    out_valid_next  = 1'b1;
                    out_fault_next  = 1'b0;
                    out_result_next = load_ext;
                end else if (timeout_hit) begin
                    // The late response still has to be swallowed before the port is reusable.
                    state_next      = ST_DRAIN;
                    out_valid_next  = 1'b1;
                    out_fault_next  = 1'b1;
                    out_result_next = addr_reg;
                end
            end
            default: begin
                if (mem_rvalid) begin
                    state_next = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_async_n) begin
        if (!rst_async_n) begin
            state_reg      <= ST_IDLE;
            cnt_reg        <= '0;
            mem_req_reg    <= 1'b0;
            mem_we_reg     <= 1'b0;
            mem_addr_reg   <= '0;
            mem_be_reg     <= '0;
            mem_wdata_reg  <= '0;
            out_valid_reg  <= 1'b0;
            out_fault_reg  <= 1'b0;
            out_result_reg <= '0;
            out_rd_reg     <= '0;
            addr_reg       <= '0;
            lane_reg       <= '0;
            size_reg       <= '0;
            unsigned_reg   <= 1'b0;
            store_reg      <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            mem_req_reg    <= mem_req_next;
            mem_we_reg     <= mem_we_next;
            mem_addr_reg   <= mem_addr_next;
            mem_be_reg     <= mem_be_next;
            mem_wdata_reg  <= mem_wdata_next;
            out_valid_reg  <= out_valid_next;
            out_fault_reg  <= out_fault_next;
            out_result_reg <= out_result_next;
            out_rd_reg     <= out_rd_next;
            addr_reg       <= addr_next;
            lane_reg       <= lane_next;
            size_reg       <= size_next;
            unsigned_reg   <= unsigned_next;
            store_reg      <= store_next;
        end
    end

    assign mem_req    = mem_req_reg;
    assign mem_we     = mem_we_reg;
    assign mem_addr   = mem_addr_reg;
    assign mem_be     = mem_be_reg;
    assign mem_wdata  = mem_wdata_reg;
    assign out_valid  = out_valid_reg;
    assign out_fault  = out_fault_reg;
    assign out_result = out_result_reg;
    assign out_rd     = out_rd_reg;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage (DATA_W 32, TIMEOUT 4): pass-through, stall, store/load
// alignment and extension, faults, both timeout paths with drain, and asynchronous reset.
module tb_mem_access_stage;
    logic        clk = 1'b0;
    logic        rst_async_n;
    logic        in_valid, in_ready, in_is_load, in_is_store, in_unsigned;
    logic [1:0]  in_size;
    logic [31:0] in_data, in_store_data;
    logic [3:0]  in_rd;
    logic        mem_req, mem_gnt, mem_we, mem_rvalid;
    logic [19:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata, mem_rdata;
    logic        out_valid, out_ready, out_fault;
    logic [3:0]  out_rd;
    logic [31:0] out_result;

    int checks = 0;
    int errors = 0;

    mem_access_stage #(.ADDR_W(20), .DATA_W(32), .IDX_W(4), .TIMEOUT(4)) dut (
        .clk(clk), .rst_async_n(rst_async_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_is_load(in_is_load),
        .in_is_store(in_is_store), .in_size(in_size), .in_unsigned(in_unsigned),
        .in_data(in_data), .in_store_data(in_store_data), .in_rd(in_rd),
        .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd),
        .out_result(out_result), .out_fault(out_fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic v, input logic ld, input logic st, input logic [1:0] sz,
                      input logic uns, input logic [31:0] d, input logic [31:0] sd,
                      input logic [3:0] rd);
        in_valid = v; in_is_load = ld; in_is_store = st; in_size = sz;
        in_unsigned = uns; in_data = d; in_store_data = sd; in_rd = rd;
        $display("op valid=%0b load=%0b store=%0b size=%0d uns=%0b data=0x%0h rd=%0d",
                 v, ld, st, sz, uns, d, rd);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_async_n = 1'b0;
        op(0, 0, 0, 0, 0, 0, 0, 0);
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0; out_ready = 1;
        step(); step();
        chk("rst_mem_req", 32'(mem_req), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_fault", 32'(out_fault), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_mem_be", 32'(mem_be), 0);
        chk("rst_out_result", out_result, 0);
        rst_async_n = 1'b1;
        step();
        chk("idle_in_ready", 32'(in_ready), 1);

        // Pass-through, back to back
        op(1, 0, 0, 0, 0, 32'hDEADBEEF, 0, 5);
        step();
        chk("pt1_valid", 32'(out_valid), 1);
        chk("pt1_result", out_result, 32'hDEADBEEF);
        chk("pt1_fault", 32'(out_fault), 0);
        chk("pt1_rd", 32'(out_rd), 5);
        op(1, 0, 0, 0, 0, 32'h12345678, 0, 6);
        step();
        chk("pt2_result", out_result, 32'h12345678);
        chk("pt2_rd", 32'(out_rd), 6);
        op(0, 0, 0, 0, 0, 0, 0, 0);
        step();
        chk("pt_drop_valid", 32'(out_valid), 0);

        // Downstream stall for 5 cycles
        op(1, 0, 0, 0, 0, 32'hCAFE0001, 0, 7);
        out_ready = 0;
        step();
        op(1, 0, 0, 0, 0, 32'h11111111, 0, 8);
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", 32'(out_valid), 1);
            chk("stall_result", out_result, 32'hCAFE0001);
            chk("stall_in_ready", 32'(in_ready), 0);
            step();
        end
        out_ready = 1;
        step();
        chk("unstall_result", out_result, 32'h11111111);
        chk("unstall_rd", 32'(out_rd), 8);
        op(0, 0, 0, 0, 0, 0, 0, 0);
        step();

        // Byte store at 0x13, grant in the third request cycle
        op(1, 0, 1, 0, 0, 32'h00013, 32'h000000AB, 1);
        step();
        op(0, 0, 0, 0, 0, 0, 0, 0);
        chk("st_req", 32'(mem_req), 1);
        chk("st_we", 32'(mem_we), 1);
        chk("st_addr", 32'(mem_addr), 32'h00010);
        chk("st_be", 32'(mem_be), 32'h8);
        chk("st_wdata", mem_wdata, 32'hABABABAB);
        chk("st_in_ready", 32'(in_ready), 0);
        step();
        chk("st_req_hold", 32'(mem_req), 1);
        step();
        chk("st_wdata_hold", mem_wdata, 32'hABABABAB);
        mem_gnt = 1;
        step();
        mem_gnt = 0;
        chk("st_req_drop", 32'(mem_req), 0);
        chk("st_out_valid", 32'(out_valid), 1);
        chk("st_result", out_result, 32'h13);
        chk("st_fault", 32'(out_fault), 0);
        step();

        // Signed half load at 0x22
        op(1, 1, 0, 1, 0, 32'h00022, 0, 2);
        step();
        op(0, 0, 0, 0, 0, 0, 0, 0);
        chk("lh_req", 32'(mem_req), 1);
        chk("lh_we", 32'(mem_we), 0);
        chk("lh_addr", 32'(mem_addr), 32'h00020);
        chk("lh_be", 32'(mem_be), 32'hC);
        mem_gnt = 1;
        step();
        mem_gnt = 0;
        chk("lh_req_drop", 32'(mem_req), 0);
        mem_rvalid = 1; mem_rdata = 32'h80011234;
        step();
        mem_rvalid = 0;
        chk("lh_valid", 32'(out_valid), 1);
        chk("lh_result", out_result, 32'hFFFF8001);
        chk("lh_rd", 32'(out_rd), 2);
        step();

        // Unsigned half load; rvalid in the grant cycle must be ignored
        op(1, 1, 0, 1, 1, 32'h00022, 0, 3);
        step();
        op(0, 0, 0, 0, 0, 0, 0, 0);
        mem_gnt = 1; mem_rvalid = 1; mem_rdata = 32'h7FFF0000;
        step();
        mem_gnt = 0; mem_rvalid = 0;
        chk("lhu_wait_valid", 32'(out_valid), 0);
        step();
        mem_rvalid = 1; mem_rdata = 32'h80011234;
        step();
        mem_rvalid = 0;
        chk("lhu_result", out_result, 32'h00008001);
        step();

        // Misaligned word load and oversize access fault without a request
        op(1, 1, 0, 2, 0, 32'h00006, 0, 3);
        step();
        op(1, 1, 0, 3, 0, 32'h00008, 0, 4);
        chk("mis_req", 32'(mem_req), 0);
        chk("mis_valid", 32'(out_valid), 1);
        chk("mis_fault", 32'(out_fault), 1);
        chk("mis_result", out_result, 32'h6);
        step();
        op(0, 0, 0, 0, 0, 0, 0, 0);
        chk("big_req", 32'(mem_req), 0);
        chk("big_fault", 32'(out_fault), 1);
        chk("big_result", out_result, 32'h8);
        step();

        // Load timeout in WAIT, drain of the late response, then a normal load
        op(1, 1, 0, 2, 0, 32'h00040, 0, 9);
        step();
        op(0, 0, 0, 0, 0, 0, 0, 0);
        mem_gnt = 1;
        step();
        mem_gnt = 0;
        step();
        step();
        chk("to_pre_valid", 32'(out_valid), 0);
        step();
        chk("to_valid", 32'(out_valid), 1);
        chk("to_fault", 32'(out_fault), 1);
        chk("to_result", out_result, 32'h40);
        chk("to_in_ready", 32'(in_ready), 0);
        op(1, 1, 0, 2, 0, 32'h00044, 0, 10);
        step();
        chk("drain_in_ready", 32'(in_ready), 0);
        chk("drain_req", 32'(mem_req), 0);
        step();
        mem_rvalid = 1; mem_rdata = 32'hBAD0BAD0;
        step();
        mem_rvalid = 0;
        chk("drain_discard_valid", 32'(out_valid), 0);
        chk("drain_done_ready", 32'(in_ready), 1);
        step();
        op(0, 0, 0, 0, 0, 0, 0, 0);
        chk("post_req", 32'(mem_req), 1);
        chk("post_addr", 32'(mem_addr), 32'h00044);
        chk("post_be", 32'(mem_be), 32'hF);
        mem_gnt = 1;
        step();
        mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h13572468;
        step();
        mem_rvalid = 0;
        chk("post_result", out_result, 32'h13572468);
        chk("post_fault", 32'(out_fault), 0);
        chk("post_rd", 32'(out_rd), 10);
        step();

        // Store never granted: timeout in REQ
        op(1, 0, 1, 2, 0, 32'h00080, 32'h5, 11);
        step();
        op(0, 0, 0, 0, 0, 0, 0, 0);
        step(); step(); step();
        chk("reqto_req_hold", 32'(mem_req), 1);
        step();
        chk("reqto_req_drop", 32'(mem_req), 0);
        chk("reqto_fault", 32'(out_fault), 1);
        chk("reqto_result", out_result, 32'h80);
        step();

        // Asynchronous reset in the middle of WAIT
        op(1, 1, 0, 2, 0, 32'h00010, 32'h55, 4);
        step();
        op(0, 0, 0, 0, 0, 0, 0, 0);
        mem_gnt = 1;
        step();
        mem_gnt = 0;
        #2 rst_async_n = 1'b0;
        #1;
        chk("arst_addr", 32'(mem_addr), 0);
        chk("arst_be", 32'(mem_be), 0);
        chk("arst_wdata", mem_wdata, 0);
        chk("arst_result", out_result, 0);
        chk("arst_rd", 32'(out_rd), 0);
        chk("arst_valid", 32'(out_valid), 0);
        step();
        rst_async_n = 1'b1;
        op(1, 0, 0, 0, 0, 32'h0000BEEF, 0, 1);
        step();
        op(0, 0, 0, 0, 0, 0, 0, 0);
        chk("after_rst_result", out_result, 32'h0000BEEF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
